// File: rtl/event_or_aggregator.sv
// Merges N event lines into sticky pending bits, drives a masked registered irq,
// and offers the lowest-numbered unmasked pending index on a valid/ready port.
module event_or_aggregator #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  evt,
    input  logic [N-1:0]  mask,
    output logic          irq,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    input  logic          out_ready,
    output logic          ovf,
    input  logic          ovf_clr
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [N-1:0]  pending_r;
    logic [N-1:0]  pending_next_s;
    logic [N-1:0]  clr_s;
    logic [N-1:0]  active_s;
    logic [IW-1:0] out_idx_r;
    logic [IW-1:0] idx_next_s;
    logic          out_valid_r;
    logic          irq_r;
    logic          ovf_r;
    logic          ovf_set_s;
    logic          pop_s;

    // Fixed-priority encoder: the lowest set bit wins.
    function automatic logic [IW-1:0] lowest_idx(input logic [N-1:0] req);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign active_s = pending_r & mask;
    assign pop_s    = (state_r == PRESENT) && out_ready;

    // Decode the popped index into a one-hot clear vector.
    always_comb begin
        clr_s = '0;
        for (int i = 0; i < N; i++) begin
            clr_s[i] = pop_s && (out_idx_r == IW'(i));
        end
    end

    // Next pending value: a new event overrides a same-cycle pop.
    always_comb begin
        pending_next_s = (pending_r & ~clr_s) | evt;
        ovf_set_s      = |(evt & pending_r & ~clr_s);
    end

    // Offer FSM next-state and index selection.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = out_idx_r;
        case (state_r)
            IDLE: begin
                if (|active_s) begin
                    state_next_s = PRESENT;
                    idx_next_s   = lowest_idx(active_s);
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = PRESENT;
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = '0;
            end
        endcase
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_idx_r   <= '0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s == PRESENT);
            out_idx_r   <= idx_next_s;
        end
    end

    // Pending, irq and overflow registers; overflow set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
            irq_r     <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            irq_r     <= |active_s;
            ovf_r     <= ovf_set_s | (ovf_r & ~ovf_clr);
        end
    end

    assign irq       = irq_r;
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_event_or_aggregator.sv
// Directed self-checking bench for event_or_aggregator (N=8).
module tb_event_or_aggregator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] evt;
    logic [7:0] mask;
    logic       irq;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_ready;
    logic       ovf;
    logic       ovf_clr;

    int total = 0;
    int bad   = 0;

    event_or_aggregator #(.N(8)) dut (
        .clk(clk), .rst(rst), .evt(evt), .mask(mask), .irq(irq),
        .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; evt = 8'h00; mask = 8'hFF; out_ready = 1'b0; ovf_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; evt = 8'h00; mask = 8'hFF; out_ready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        total++;
        if ({irq, out_valid, out_idx, ovf} !== 6'b0) begin
            $display("FAIL reset_state got=%b exp=%b", {irq, out_valid, out_idx, ovf}, 6'b0); bad++;
        end
        rst = 1'b0; evt = 8'h04;
        step();
        evt = 8'h00;
        total++;
        if ({irq, out_valid} !== 2'b00) begin
            $display("FAIL reset_lat1 got=%b exp=00", {irq, out_valid}); bad++;
        end
        step();
        total++;
        if ({irq, out_valid, out_idx} !== 5'b11_010) begin
            $display("FAIL reset_lat2 got=%b exp=11010", {irq, out_valid, out_idx}); bad++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({irq, out_valid, out_idx} !== 5'b0) begin
            $display("FAIL reset_mid_offer got=%b exp=00000", {irq, out_valid, out_idx}); bad++;
        end
        step(); step();
        total++;
        if ({irq, out_valid} !== 2'b00) begin
            $display("FAIL reset_no_reoffer got=%b exp=00", {irq, out_valid}); bad++;
        end
    endtask

    task automatic test_priority();
        logic [6:0] exp_v;
        logic [6:0] exp_irq;
        logic [2:0] exp_idx [7];
        exp_v   = 7'b0010101;   // bit k = expectation after edge k+1
        exp_irq = 7'b0111111;
        exp_idx = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd7, 3'd0, 3'd0};
        do_reset();
        out_ready = 1'b1; evt = 8'hA1;
        step();
        evt = 8'h00;
        total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL prio_first_edge got=%b exp=0", out_valid); bad++;
        end
        for (int k = 0; k < 7; k++) begin
            step();
            total++;
            if ({out_valid, irq} !== {exp_v[k], exp_irq[k]}) begin
                $display("FAIL prio_valid_irq step=%0d got=%b exp=%b", k, {out_valid, irq}, {exp_v[k], exp_irq[k]}); bad++;
            end
            if (exp_v[k]) begin
                total++;
                if (out_idx !== exp_idx[k]) begin
                    $display("FAIL prio_idx step=%0d got=%0d exp=%0d", k, out_idx, exp_idx[k]); bad++;
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_masking();
        do_reset();
        mask = 8'h0F; evt = 8'h30;
        step();
        evt = 8'h00;
        step(); step();
        total++;
        if ({irq, out_valid} !== 2'b00) begin
            $display("FAIL mask_hidden got=%b exp=00", {irq, out_valid}); bad++;
        end
        mask = 8'hFF;
        step();
        total++;
        if ({irq, out_valid, out_idx} !== 5'b11_100) begin
            $display("FAIL mask_reveal got=%b exp=11100", {irq, out_valid, out_idx}); bad++;
        end
        out_ready = 1'b1;
        step(); step();
        total++;
        if ({out_valid, out_idx} !== 4'b1_101) begin
            $display("FAIL mask_second got=%b exp=1101", {out_valid, out_idx}); bad++;
        end
        step();
        out_ready = 1'b0;
        step();
        total++;
        if ({irq, out_valid} !== 2'b00) begin
            $display("FAIL mask_drained got=%b exp=00", {irq, out_valid}); bad++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        evt = 8'h08;
        step();
        evt = 8'h00;
        step();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                evt = 8'h01; mask = 8'hF7;
            end else begin
                evt = 8'h00;
            end
            step();
            total++;
            if ({out_valid, out_idx} !== 4'b1_011) begin
                $display("FAIL bp_hold cycle=%0d got=%b exp=1011", k, {out_valid, out_idx}); bad++;
            end
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_pop got=%b exp=0", out_valid); bad++;
        end
        step();
        total++;
        if ({out_valid, out_idx} !== 4'b1_000) begin
            $display("FAIL bp_next got=%b exp=1000", {out_valid, out_idx}); bad++;
        end
        step();
        out_ready = 1'b0; mask = 8'hFF;
        step();
        total++;
        if ({irq, out_valid, ovf} !== 3'b000) begin
            $display("FAIL bp_drained got=%b exp=000", {irq, out_valid, ovf}); bad++;
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        evt = 8'h04;
        step();
        evt = 8'h00;
        step();
        out_ready = 1'b1; evt = 8'h04;
        step();
        out_ready = 1'b0; evt = 8'h00;
        total++;
        if ({out_valid, ovf} !== 2'b00) begin
            $display("FAIL setwins_bubble got=%b exp=00", {out_valid, ovf}); bad++;
        end
        step();
        total++;
        if ({irq, out_valid, out_idx, ovf} !== 6'b11_010_0) begin
            $display("FAIL setwins_reoffer got=%b exp=110100", {irq, out_valid, out_idx, ovf}); bad++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        total++;
        if ({irq, out_valid, ovf} !== 3'b000) begin
            $display("FAIL setwins_drained got=%b exp=000", {irq, out_valid, ovf}); bad++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        evt = 8'h02;
        step();
        total++;
        if (ovf !== 1'b0) begin
            $display("FAIL ovf_first got=%b exp=0", ovf); bad++;
        end
        step();
        evt = 8'h00;
        total++;
        if (ovf !== 1'b1) begin
            $display("FAIL ovf_second got=%b exp=1", ovf); bad++;
        end
        step(); step();
        total++;
        if ({ovf, out_valid, out_idx} !== 5'b1_1_001) begin
            $display("FAIL ovf_sticky got=%b exp=11001", {ovf, out_valid, out_idx}); bad++;
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        total++;
        if (ovf !== 1'b0) begin
            $display("FAIL ovf_clear got=%b exp=0", ovf); bad++;
        end
        evt = 8'h02; ovf_clr = 1'b1;
        step();
        evt = 8'h00; ovf_clr = 1'b0;
        step();
        total++;
        if (ovf !== 1'b1) begin
            $display("FAIL ovf_set_beats_clr got=%b exp=1", ovf); bad++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; evt = 8'h00; mask = 8'hFF; out_ready = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_priority();
        test_masking();
        test_backpressure();
        test_set_wins();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
